vga_timing_driver: RTL

- Pixel-timing generator sitting directly downstream of the game's pixel compositor.
- Produces horizontal/vertical sync and display-enable, and issues pixel_xpos/pixel_ypos requests DATA_LAT cycles ahead of display.
- Accepts the compositor's returned 16-bit RGB565 pixel_data and gates it onto vga_rgb during the active window.
- Also emits a one-cycle frame_start pulse, which game logic uses as a frame tick.

---
 rtl/vga_timing_driver.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_timing_driver.sv
// rtl/vga_timing_driver.sv - VGA sync/DE generator issuing pixel requests DATA_LAT clocks ahead of display
module vga_timing_driver #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_DISP   = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_DISP   = 480,
  parameter int   V_FRONT  = 10,
  parameter int   DATA_LAT = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  // Window bounds are 12 bits so an end bound of exactly 2048 still compares correctly.
  localparam logic [11:0] HS_END = 12'(H_SYNC);
  localparam logic [11:0] VS_END = 12'(V_SYNC);
  localparam logic [11:0] HA_BEG = 12'(HA);
  localparam logic [11:0] HA_END = 12'(HA + H_DISP);
  localparam logic [11:0] VA_BEG = 12'(VA);
  localparam logic [11:0] VA_END = 12'(VA + V_DISP);
  localparam logic [11:0] RQ_BEG = 12'(HA - DATA_LAT);
  localparam logic [11:0] RQ_END = 12'(HA + H_DISP - DATA_LAT);
  localparam logic [10:0] RQ_OFF = 11'(HA - DATA_LAT);
  localparam logic [10:0] VA_OFF = 11'(VA);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("vga_timing_driver: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end
  if (DATA_LAT < 0 || DATA_LAT > HA - 1) begin : g_bad_lat
    $error("vga_timing_driver: DATA_LAT outside 0..H_SYNC+H_BACK-1");
  end

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic        hs_act;
  logic        vs_act;
  logic        v_win;
  logic        active;
  logic        req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_comb begin
    h_ext  = {1'b0, h_cnt};
    v_ext  = {1'b0, v_cnt};
    hs_act = h_ext < HS_END;
    vs_act = v_ext < VS_END;
    v_win  = (v_ext >= VA_BEG) && (v_ext < VA_END);
    active = (h_ext >= HA_BEG) && (h_ext < HA_END) && v_win;
    req    = (h_ext >= RQ_BEG) && (h_ext < RQ_END) && v_win;
  end

  // Every output is registered from the counters so nothing glitches across wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
    end else begin
      vga_hs      <= hs_act ? SYNC_POL : ~SYNC_POL;
      vga_vs      <= vs_act ? SYNC_POL : ~SYNC_POL;
      vga_de      <= active;
      frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
      pixel_xpos  <= req ? (h_cnt - RQ_OFF) : 11'd0;
      pixel_ypos  <= req ? (v_cnt - VA_OFF) : 11'd0;
    end
  end

  // Blanking forces black whatever the compositor is returning.
  assign vga_rgb = vga_de ? pixel_data : 16'h0000;

endmodule
